// File: rtl/stratix_lcell_comb_if.sv
`default_nettype none
// ============================================================================
// Module   : stratix_lcell_comb_if
// Brief    : Signal bundle for one adaptive-LUT combinational cell: LUT
//            inputs, carry/share chain and the combinational/registered
//            outputs. The master drives inputs, the slave is the cell.
// Revision : 1.0 - initial release
// ============================================================================
interface stratix_lcell_comb_if;
  logic ena;
  logic dataa;
  logic datab;
  logic datac;
  logic datad;
  logic datae;
  logic dataf;
  logic datag;
  logic cin;
  logic sharein;
  logic combout;
  logic sumout;
  logic cout;
  logic shareout;
  logic regout;

  modport master (
    output ena, dataa, datab, datac, datad, datae, dataf, datag, cin, sharein,
    input  combout, sumout, cout, shareout, regout
  );

  modport slave (
    input  ena, dataa, datab, datac, datad, datae, dataf, datag, cin, sharein,
    output combout, sumout, cout, shareout, regout
  );
endinterface
`default_nettype wire

// File: rtl/stratix_lcell_comb.sv
`default_nettype none
// ============================================================================
// Module   : stratix_lcell_comb
// Brief    : Behavioural half-ALM for Stratix IV / V: 6-input LUT with an
//            optional 7-input extended mode, carry-chain adder with optional
//            shared (ternary) arithmetic, and an optional output register.
// Revision : 1.0 - initial release
// ============================================================================
module stratix_lcell_comb #(
  parameter logic [63:0] LUT_MASK     = 64'h0,
  parameter string       SHARED_ARITH = "off",
  parameter string       EXTENDED_LUT = "off"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stratix_lcell_comb_if.slave  bus
);

  // Anything other than exactly "on" behaves as "off".
  localparam bit c_shared = (SHARED_ARITH == "on");
  localparam bit c_ext    = (EXTENDED_LUT == "on");

  // Binary mux tree over the mask. Built from ?: so that an unknown select
  // only yields X when the addressable mask bits actually disagree.
  function automatic logic f_mux64(input logic [63:0] m, input logic [5:0] s);
    logic [31:0] l1;
    logic [15:0] l2;
    logic [7:0]  l3;
    logic [3:0]  l4;
    logic [1:0]  l5;
    for (int i = 0; i < 32; i++) l1[i] = s[0] ? m[2*i+1]  : m[2*i];
    for (int i = 0; i < 16; i++) l2[i] = s[1] ? l1[2*i+1] : l1[2*i];
    for (int i = 0; i < 8;  i++) l3[i] = s[2] ? l2[2*i+1] : l2[2*i];
    for (int i = 0; i < 4;  i++) l4[i] = s[3] ? l3[2*i+1] : l3[2*i];
    for (int i = 0; i < 2;  i++) l5[i] = s[4] ? l4[2*i+1] : l4[2*i];
    return s[5] ? l5[1] : l5[0];
  endfunction

  function automatic logic f_maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [5:0] w_idx_norm;
  logic [5:0] w_idx_ext;
  logic [5:0] w_idx;
  logic       w_combout;
  logic [3:0] w_n;
  logic       w_f0;
  logic       w_f1;
  logic       w_f2;
  logic       w_p;
  logic       w_share;
  logic       w_add_a;
  logic       w_add_b;
  logic       r_regout;

  // LUT index: in extended mode dataf picks between the lower half (datae
  // as bit 4) and the upper half (datag replaces datae as bit 4).
  assign w_idx_norm = {bus.dataf, bus.datae, bus.datad, bus.datac, bus.datab, bus.dataa};
  assign w_idx_ext  = bus.dataf ? {1'b1, bus.datag, bus.datad, bus.datac, bus.datab, bus.dataa}
                                : {1'b0, bus.datae, bus.datad, bus.datac, bus.datab, bus.dataa};
  assign w_idx      = c_ext ? w_idx_ext : w_idx_norm;
  assign w_combout  = f_mux64(LUT_MASK, w_idx);

  // Arithmetic sub-LUTs share the 4-input index: F0 at bits 0-15,
  // F2 at bits 16-31, F1 at bits 32-47.
  assign w_n  = {bus.datad, bus.datac, bus.datab, bus.dataa};
  assign w_f0 = f_mux64(LUT_MASK, {2'b00, w_n});
  assign w_f2 = f_mux64(LUT_MASK, {2'b01, w_n});
  assign w_f1 = f_mux64(LUT_MASK, {2'b10, w_n});

  // Ternary mode first compresses F0+F1+F2 into a partial sum and a share
  // bit passed to the neighbouring cell; the adder then sums P with sharein.
  assign w_p     = w_f0 ^ w_f1 ^ w_f2;
  assign w_share = f_maj(w_f0, w_f1, w_f2);
  assign w_add_a = c_shared ? w_p : w_f0;
  assign w_add_b = c_shared ? bus.sharein : w_f1;

  assign bus.combout  = w_combout;
  assign bus.sumout   = w_add_a ^ w_add_b ^ bus.cin;
  assign bus.cout     = f_maj(w_add_a, w_add_b, bus.cin);
  assign bus.shareout = c_shared ? w_share : 1'b0;
  assign bus.regout   = r_regout;

  // Output register: async clear, captures combout when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regout <= 1'b0;
    end else if (bus.ena) begin
      r_regout <= w_combout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stratix_lcell_comb.sv
`default_nettype none
// ============================================================================
// Module   : tb_stratix_lcell_comb
// Brief    : Self-checking bench for stratix_lcell_comb; several instances
//            with different masks/modes share one input bundle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stratix_lcell_comb;

  localparam logic [63:0] c_xor = 64'h6996966996696996;
  localparam logic [63:0] c_eq  = 64'h8040201008040201;
  localparam logic [63:0] c_ext = 64'hFFFF000000000000;
  localparam logic [63:0] c_add = 64'h0000CCCC0000AAAA;
  localparam logic [63:0] c_sh  = 64'h0000CCCCF0F0AAAA;

  typedef struct {
    string      name;
    logic [2:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] din = '0;  // {g,f,e,d,c,b,a}
  logic       cin = 1'b0;
  logic       sharein = 1'b0;
  logic       ena = 1'b0;

  always #5 clk = ~clk;

  stratix_lcell_comb_if b_xor ();
  stratix_lcell_comb_if b_eq ();
  stratix_lcell_comb_if b_exton ();
  stratix_lcell_comb_if b_extoff ();
  stratix_lcell_comb_if b_add ();
  stratix_lcell_comb_if b_sh ();

  assign {b_xor.datag, b_xor.dataf, b_xor.datae, b_xor.datad, b_xor.datac, b_xor.datab, b_xor.dataa} = din;
  assign {b_xor.cin, b_xor.sharein, b_xor.ena} = {cin, sharein, ena};
  assign {b_eq.datag, b_eq.dataf, b_eq.datae, b_eq.datad, b_eq.datac, b_eq.datab, b_eq.dataa} = din;
  assign {b_eq.cin, b_eq.sharein, b_eq.ena} = {cin, sharein, ena};
  assign {b_exton.datag, b_exton.dataf, b_exton.datae, b_exton.datad, b_exton.datac, b_exton.datab, b_exton.dataa} = din;
  assign {b_exton.cin, b_exton.sharein, b_exton.ena} = {cin, sharein, ena};
  assign {b_extoff.datag, b_extoff.dataf, b_extoff.datae, b_extoff.datad, b_extoff.datac, b_extoff.datab, b_extoff.dataa} = din;
  assign {b_extoff.cin, b_extoff.sharein, b_extoff.ena} = {cin, sharein, ena};
  assign {b_add.datag, b_add.dataf, b_add.datae, b_add.datad, b_add.datac, b_add.datab, b_add.dataa} = din;
  assign {b_add.cin, b_add.sharein, b_add.ena} = {cin, sharein, ena};
  assign {b_sh.datag, b_sh.dataf, b_sh.datae, b_sh.datad, b_sh.datac, b_sh.datab, b_sh.dataa} = din;
  assign {b_sh.cin, b_sh.sharein, b_sh.ena} = {cin, sharein, ena};

  stratix_lcell_comb #(.LUT_MASK(c_xor)) u_xor (.clk(clk), .rst_n(rst_n), .bus(b_xor.slave));
  stratix_lcell_comb #(.LUT_MASK(c_eq))  u_eq  (.clk(clk), .rst_n(rst_n), .bus(b_eq.slave));
  stratix_lcell_comb #(.LUT_MASK(c_ext), .EXTENDED_LUT("on"))  u_exton  (.clk(clk), .rst_n(rst_n), .bus(b_exton.slave));
  stratix_lcell_comb #(.LUT_MASK(c_ext), .EXTENDED_LUT("off")) u_extoff (.clk(clk), .rst_n(rst_n), .bus(b_extoff.slave));
  stratix_lcell_comb #(.LUT_MASK(c_add), .SHARED_ARITH("off")) u_add (.clk(clk), .rst_n(rst_n), .bus(b_add.slave));
  stratix_lcell_comb #(.LUT_MASK(c_sh),  .SHARED_ARITH("on"))  u_sh  (.clk(clk), .rst_n(rst_n), .bus(b_sh.slave));

  // Reference LUT lookup straight from the truth-table definition.
  function automatic logic m_comb(input logic [63:0] mask, input bit ext, input logic [6:0] d);
    logic [5:0] idx;
    if (!ext)      idx = d[5:0];
    else if (d[5]) idx = {1'b1, d[6], d[3:0]};
    else           idx = {1'b0, d[4:0]};
    return mask[idx];
  endfunction

  // Reference arithmetic via integer addition; returns {sumout,cout,shareout}.
  function automatic logic [2:0] m_arith(input logic [63:0] mask, input bit shared,
                                         input logic [3:0] n, input logic ci, input logic si);
    int f0, f1, f2, t3, t;
    f0 = int'(mask[n]);
    f2 = int'(mask[16 + int'(n)]);
    f1 = int'(mask[32 + int'(n)]);
    if (!shared) begin
      t = f0 + f1 + int'(ci);
      return {t[0], t[1], 1'b0};
    end
    t3 = f0 + f1 + f2;
    t  = (t3 % 2) + int'(si) + int'(ci);
    return {t[0], t[1], (t3 >= 2)};
  endfunction

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; ena = 1'b1; din = 7'b0000001;
    repeat (2) @(negedge clk);
    #1;
    q.push_back('{"reset_regout", 3'b000});
    q.push_back('{"reset_comb_follows", 3'b001});
    e = q.pop_front(); n_cmp++;
    if (b_xor.regout !== e.exp[0]) begin
      n_err++; $display("FAIL %s: got %b expected %b", e.name, b_xor.regout, e.exp[0]);
    end
    e = q.pop_front(); n_cmp++;
    if (b_xor.combout !== e.exp[0]) begin
      n_err++; $display("FAIL %s: got %b expected %b", e.name, b_xor.combout, e.exp[0]);
    end
  endtask

  task automatic test_xor6();
    exp_t e;
    logic [6:0] pat [3] = '{7'b0000001, 7'b0111111, 7'b0000000};
    logic       exp_v [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3 + 64; i++) begin
      @(negedge clk);
      if (i < 3) begin
        din = pat[i];
        q.push_back('{$sformatf("xor6_spec%0d", i), {2'b00, exp_v[i]}});
      end else begin
        din = 7'(i - 3);
        q.push_back('{$sformatf("xor6_idx%0d", i - 3), {2'b00, ^din[5:0]}});
      end
      #1;
      e = q.pop_front(); n_cmp++;
      if (b_xor.combout !== e.exp[0]) begin
        n_err++; $display("FAIL %s: got %b expected %b", e.name, b_xor.combout, e.exp[0]);
      end
    end
  endtask

  task automatic test_equality();
    exp_t e;
    logic [6:0] pat [2] = '{7'b0001001, 7'b0000001};
    logic       exp_v [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2 + 64; i++) begin
      @(negedge clk);
      if (i < 2) begin
        din = pat[i];
        q.push_back('{$sformatf("eq_spec%0d", i), {2'b00, exp_v[i]}});
      end else begin
        din = 7'(i - 2);
        q.push_back('{$sformatf("eq_idx%0d", i - 2), {2'b00, m_comb(c_eq, 1'b0, din)}});
      end
      #1;
      e = q.pop_front(); n_cmp++;
      if (b_eq.combout !== e.exp[0]) begin
        n_err++; $display("FAIL %s: got %b expected %b", e.name, b_eq.combout, e.exp[0]);
      end
    end
  endtask

  task automatic test_extended();
    exp_t e;
    // Spec vectors: on/f=1,g=1,e=0 -> 1; on/f=1,g=0,e=1 -> 0; off/same -> 1
    @(negedge clk);
    din = 7'b1100000;
    q.push_back('{"ext_on_g1", 3'b001});
    #1;
    e = q.pop_front(); n_cmp++;
    if (b_exton.combout !== e.exp[0]) begin
      n_err++; $display("FAIL %s: got %b expected %b", e.name, b_exton.combout, e.exp[0]);
    end
    @(negedge clk);
    din = 7'b0110000;
    q.push_back('{"ext_on_g0_e1", 3'b000});
    q.push_back('{"ext_off_e1", 3'b001});
    #1;
    e = q.pop_front(); n_cmp++;
    if (b_exton.combout !== e.exp[0]) begin
      n_err++; $display("FAIL %s: got %b expected %b", e.name, b_exton.combout, e.exp[0]);
    end
    e = q.pop_front(); n_cmp++;
    if (b_extoff.combout !== e.exp[0]) begin
      n_err++; $display("FAIL %s: got %b expected %b", e.name, b_extoff.combout, e.exp[0]);
    end
    // Full 7-input sweep on both instances with a pseudo-random stride.
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      din = 7'((i * 37 + 11) % 128);
      q.push_back('{$sformatf("ext_on_%0d", din), {2'b00, m_comb(c_ext, 1'b1, din)}});
      q.push_back('{$sformatf("ext_off_%0d", din), {2'b00, m_comb(c_ext, 1'b0, din)}});
      #1;
      e = q.pop_front(); n_cmp++;
      if (b_exton.combout !== e.exp[0]) begin
        n_err++; $display("FAIL %s: got %b expected %b", e.name, b_exton.combout, e.exp[0]);
      end
      e = q.pop_front(); n_cmp++;
      if (b_extoff.combout !== e.exp[0]) begin
        n_err++; $display("FAIL %s: got %b expected %b", e.name, b_extoff.combout, e.exp[0]);
      end
    end
  endtask

  task automatic test_adder();
    exp_t e;
    logic [2:0] obs;
    @(negedge clk);
    din = 7'b0000011; cin = 1'b0; sharein = 1'b0;
    q.push_back('{"add_ab_cin0", 3'b010});
    #1;
    e = q.pop_front(); n_cmp++;
    obs = {b_add.sumout, b_add.cout, b_add.shareout};
    if (obs !== e.exp) begin
      n_err++; $display("FAIL %s: got {sum,cout,share}=%b expected %b", e.name, obs, e.exp);
    end
    @(negedge clk);
    cin = 1'b1;
    q.push_back('{"add_ab_cin1", 3'b110});
    #1;
    e = q.pop_front(); n_cmp++;
    obs = {b_add.sumout, b_add.cout, b_add.shareout};
    if (obs !== e.exp) begin
      n_err++; $display("FAIL %s: got {sum,cout,share}=%b expected %b", e.name, obs, e.exp);
    end
    // Sweep index x cin x sharein; sharein and upper inputs must not matter.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      din = {3'(i * 5), 4'(i % 16)};
      cin = 1'(i / 16); sharein = 1'(i / 32);
      q.push_back('{$sformatf("add_sweep%0d", i), m_arith(c_add, 1'b0, din[3:0], cin, sharein)});
      #1;
      e = q.pop_front(); n_cmp++;
      obs = {b_add.sumout, b_add.cout, b_add.shareout};
      if (obs !== e.exp) begin
        n_err++; $display("FAIL %s: got {sum,cout,share}=%b expected %b", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_shared();
    exp_t e;
    logic [2:0] obs;
    logic [1:0] ctl [2] = '{2'b00, 2'b11};  // {sharein,cin}
    logic [2:0] exp_v [2] = '{3'b101, 3'b111};
    for (int i = 0; i < 2 + 64; i++) begin
      @(negedge clk);
      if (i < 2) begin
        din = 7'b0000111;
        {sharein, cin} = ctl[i];
        q.push_back('{$sformatf("shared_spec%0d", i), exp_v[i]});
      end else begin
        din = {3'(i * 3), 4'((i - 2) % 16)};
        cin = 1'((i - 2) / 16); sharein = 1'((i - 2) / 32);
        q.push_back('{$sformatf("shared_sweep%0d", i - 2), m_arith(c_sh, 1'b1, din[3:0], cin, sharein)});
      end
      #1;
      e = q.pop_front(); n_cmp++;
      obs = {b_sh.sumout, b_sh.cout, b_sh.shareout};
      if (obs !== e.exp) begin
        n_err++; $display("FAIL %s: got {sum,cout,share}=%b expected %b", e.name, obs, e.exp);
      end
    end
    cin = 1'b0; sharein = 1'b0;
  endtask

  task automatic test_register();
    exp_t e;
    // Release reset, capture combout=1 on the next edge.
    @(negedge clk);
    rst_n = 1'b1; ena = 1'b1; din = 7'b0000001;
    q.push_back('{"reg_capture", 3'b001});
    @(posedge clk); #1;
    e = q.pop_front(); n_cmp++;
    if (b_xor.regout !== e.exp[0]) begin
      n_err++; $display("FAIL %s: got %b expected %b", e.name, b_xor.regout, e.exp[0]);
    end
    // Enable low: input change must not reach regout.
    @(negedge clk);
    ena = 1'b0; din = 7'b0000000;
    q.push_back('{"reg_hold", 3'b001});
    @(posedge clk); #1;
    e = q.pop_front(); n_cmp++;
    if (b_xor.regout !== e.exp[0]) begin
      n_err++; $display("FAIL %s: got %b expected %b", e.name, b_xor.regout, e.exp[0]);
    end
    // Asynchronous clear between edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.push_back('{"reg_async_clear", 3'b000});
    e = q.pop_front(); n_cmp++;
    if (b_xor.regout !== e.exp[0]) begin
      n_err++; $display("FAIL %s: got %b expected %b", e.name, b_xor.regout, e.exp[0]);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [6:0] pat [4] = '{7'b0000111, 7'b0000011, 7'b0111110, 7'b0101010};
    @(negedge clk);
    rst_n = 1'b1; ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = pat[i];
      q.push_back('{$sformatf("reg_b2b%0d", i), {2'b00, ^pat[i][5:0]}});
      @(posedge clk); #1;
      e = q.pop_front(); n_cmp++;
      if (b_xor.regout !== e.exp[0]) begin
        n_err++; $display("FAIL %s: got %b expected %b", e.name, b_xor.regout, e.exp[0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_xor6();
    test_equality();
    test_extended();
    test_adder();
    test_shared();
    test_register();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stratix_lcell_comb.md
# stratix_lcell_comb

Behavioural model of one Stratix IV / Stratix V adaptive-LUT combinational cell (half-ALM). It is the primitive that generic LUT wrappers instantiate for their family-specific branches. It provides a 64-bit-mask 6-input LUT, an optional 7-input extended-LUT mode, and a carry-chain adder with optional shared (ternary) arithmetic. It also carries an optional output register. Both family primitives map onto this one model; behaviour is identical for either family.

## Interface
- `LUT_MASK`, default 64'h0, truth table; bit *i* is the output for LUT index *i*.
- `SHARED_ARITH`, default "off", "on" enables ternary-adder mode; any other value is treated as "off".
- `EXTENDED_LUT`, default "off", "on" enables 7-input mode; any other value is treated as "off".
- `clk`  in  1  register clock, rising edge. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low clear of `regout`.
- `ena`  in  1  clock enable for `regout`.
- `dataa`..`dataf`  in  1 each  LUT inputs; `dataa` is the index LSB.
- `datag`  in  1  seventh input, used only in extended mode.
- `cin`  in  1  carry in.
- `sharein`  in  1  shared-arithmetic input.
- `combout`  out  1  LUT output.
- `sumout`  out  1  adder sum.
- `cout`  out  1  carry out.
- `shareout`  out  1  shared-arithmetic output.
- `regout`  out  1  registered `combout`.

## Operation
- Normal LUT mode (`EXTENDED_LUT` off): `combout` = `LUT_MASK[{dataf,datae,datad,datac,datab,dataa}]`. `datag` is ignored.
- Extended mode (`EXTENDED_LUT` on):
  - `dataf`=0: `combout` = `LUT_MASK[{1'b0,datae,datad,datac,datab,dataa}]`.
  - `dataf`=1: `combout` = `LUT_MASK[{1'b1,datag,datad,datac,datab,dataa}]`; `datae` is ignored.
- Arithmetic sub-LUTs, each indexed by n = `{datad,datac,datab,dataa}`:
  - F0 = `LUT_MASK[n]`
  - F2 = `LUT_MASK[16+n]`
  - F1 = `LUT_MASK[32+n]`
- `SHARED_ARITH` off:
  - `sumout` = F0^F1^`cin`
  - `cout` = maj(F0,F1,`cin`)
  - `shareout` = 0
  - `sharein` and F2 are ignored.
- `SHARED_ARITH` on:
  - P = F0^F1^F2
  - `shareout` = maj(F0,F1,F2)
  - `sumout` = P^`sharein`^`cin`
  - `cout` = maj(P,`sharein`,`cin`)
- `combout` is always driven, in all modes. The arithmetic outputs are always driven, even when unused.
- X/Z on any index input: `combout` = X unless all mask bits addressable by the resolved inputs agree; in that case it equals their common value. Arithmetic outputs follow the same rule.
- Register:
  - `rst_n`=0: `regout`=0 immediately, regardless of `clk`.
  - Otherwise, on rising `clk` with `ena`=1: `regout` <= `combout`.
  - `ena`=0: `regout` holds.
- Parameter values are static; there is no runtime mode change.

## Timing
- `combout`, `sumout`, `cout` and `shareout` are purely combinational, zero-cycle latency, and insensitive to `clk` and `rst_n`.
- `regout` has 1-cycle latency from `combout`.
- Reset value of `regout` is 0. All other outputs have no reset state; they follow the inputs during reset.
- Reset assertion mid-operation clears `regout` asynchronously.
- Reset deassertion takes effect at the next rising edge. If `rst_n` rises coincident with an edge, that edge is ignored; capture starts at the following edge.
- `cin` to `cout` is a single combinational path, so chained cells ripple within one cycle.

## Test plan
- XOR6 check, `LUT_MASK`=64'h6996966996696996:
  - `dataa`=1, others 0 -> `combout`=1.
  - All six inputs 1 -> `combout`=0.
  - Sweep all 64 indices against the parity of the index.
- Equality mask, `LUT_MASK`=64'h8040201008040201:
  - `dataa`=`datad`=1, others 0 -> `combout`=1.
  - `dataa`=1 only -> `combout`=0.
- Extended LUT, `LUT_MASK`=64'hFFFF000000000000, inputs `dataf`=1, `datag`=1, `datae`=0:
  - `EXTENDED_LUT` on -> `combout`=1.
  - `dataf`=1, `datag`=0, `datae`=1 -> `combout`=0.
  - Same inputs with `EXTENDED_LUT` off -> `combout`=1.
- Adder, `LUT_MASK`=64'h0000CCCC0000AAAA, `SHARED_ARITH` off:
  - `dataa`=`datab`=1, `cin`=0 -> `sumout`=0, `cout`=1, `shareout`=0.
  - Same with `cin`=1 -> `sumout`=1, `cout`=1.
- Shared arithmetic, `LUT_MASK`=64'h0000CCCCF0F0AAAA, `SHARED_ARITH` on:
  - `dataa`=`datab`=`datac`=1, `sharein`=0, `cin`=0 -> `shareout`=1, `sumout`=1, `cout`=0.
  - `sharein`=1, `cin`=1 -> `sumout`=1, `cout`=1.
- Register, XOR6 mask:
  - `rst_n`=0 -> `regout`=0 immediately.
  - Release reset, `dataa`=1, `ena`=1 -> `regout`=1 after one rising edge.
  - `ena`=0 with input change -> `regout` holds.
  - Assert `rst_n`=0 between edges -> `regout`=0 without a clock.
